// File: rtl/ifetch.sv
// ifetch: instruction-fetch sequencer between the pc counter and the synchronous ROM.
// Fetches the word at pc into ir, offers it to decode with a valid/ready handshake and
// pulses pc_en once per captured word so the pc counter advances.
// Optional build macro: IFETCH_HALT_DETECT_EN adds halt-opcode detection and a HALT state.
module ifetch #(
  parameter int              AW      = 5,
  parameter int              DW      = 8,
  parameter int              MEM_LAT = 1,
  parameter logic [DW-1:0]   HALT_OP = DW'(8'hFF)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          run,
  input  logic [AW-1:0] pc,
  output logic          pc_en,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] ir,
  output logic          ir_valid,
  input  logic          ir_ready,
  output logic          halted
);

`ifdef IFETCH_HALT_DETECT_EN
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALT} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
`endif

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [DW-1:0] ir_q, ir_d;
  logic          ir_valid_q, ir_valid_d;
  logic          pc_en_q, pc_en_d;
  logic          halt_word;

`ifdef IFETCH_HALT_DETECT_EN
  assign halt_word = (mem_rdata == HALT_OP);
  assign halted    = (state_q == HALT);
`else
  logic unused_halt_op;
  assign unused_halt_op = ^HALT_OP;
  assign halt_word      = 1'b0;
  assign halted         = 1'b0;
`endif

  assign mem_addr = pc;
  assign mem_rd   = (state_q == REQ);
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign pc_en    = pc_en_q;

  // State, wait counter, instruction register and registered pc_en pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      pc_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      pc_en_q    <= pc_en_d;
    end
  end

  // Next-state logic; pc_en_d is set only when leaving WAIT so the pulse lands in the first HOLD cycle
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    pc_en_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) state_d = REQ;
      end
      REQ: begin
        cnt_d   = 2'(MEM_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          ir_d       = mem_rdata;
          ir_valid_d = 1'b1;
          pc_en_d    = ~halt_word;
          state_d    = HOLD;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      HOLD: begin
        if (ir_valid_q && ir_ready) begin
          ir_valid_d = 1'b0;
`ifdef IFETCH_HALT_DETECT_EN
          if (ir_q == HALT_OP) state_d = HALT;
          else if (run)        state_d = REQ;
          else                 state_d = IDLE;
`else
          state_d = run ? REQ : IDLE;
`endif
        end
      end
`ifdef IFETCH_HALT_DETECT_EN
      HALT: begin
        state_d = HALT;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

endmodule
